// File: rtl/tpu_pass_sched_pkg.sv
// Shared types and constants for the TPU pass scheduler: FSM state
// encodings, error codes and the address/counter widths.
package tpu_pass_sched_pkg;

  localparam int W_AW = 6;  // weight SRAM word address width
  localparam int V_AW = 5;  // vector SRAM word address width
  localparam int O_AW = 6;  // output SRAM word address width
  localparam int M_W  = 6;  // output tile count / index width
  localparam int K_W  = 5;  // K pass count / index width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/tpu_pass_sched_addr_gen.sv
// Registered SRAM base-address generator. The pass index multiply is
// evaluated from the scheduler's next-state indices and captured when the
// FSM enters ISSUE, so the bases are valid for the whole ISSUE/WAIT window.
module tpu_pass_sched_addr_gen
  import tpu_pass_sched_pkg::*;
#(
  parameter int W_STRIDE = 8,
  parameter int V_STRIDE = 8
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            load_i,
  input  logic [M_W-1:0]  m_idx_i,
  input  logic [K_W-1:0]  k_idx_i,
  input  logic [K_W-1:0]  k_tiles_i,
  input  logic [W_AW-1:0] w_base_i,
  input  logic [V_AW-1:0] v_base_i,
  output logic [W_AW-1:0] w_addr_o,
  output logic [V_AW-1:0] v_addr_o
);

  // 63*31 + 30 = 1983 fits in 11 bits
  logic [10:0]     pass_s;
  logic [W_AW-1:0] w_addr_d;
  logic [V_AW-1:0] v_addr_d;
  logic [W_AW-1:0] w_addr_q;
  logic [V_AW-1:0] v_addr_q;

  // Linear pass number and wrapped base addresses for the upcoming pass
  always_comb begin
    pass_s   = 11'(m_idx_i) * 11'(k_tiles_i) + 11'(k_idx_i);
    w_addr_d = w_base_i + W_AW'(pass_s * W_STRIDE);
    v_addr_d = v_base_i + V_AW'(k_idx_i * V_STRIDE);
  end

  // Capture the bases on ISSUE entry, hold them otherwise
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      w_addr_q <= {W_AW{1'b0}};
      v_addr_q <= {V_AW{1'b0}};
    end else if (load_i) begin
      w_addr_q <= w_addr_d;
      v_addr_q <= v_addr_d;
    end else begin
      w_addr_q <= w_addr_q;
      v_addr_q <= v_addr_q;
    end
  end

  assign w_addr_o = w_addr_q;
  assign v_addr_o = v_addr_q;

endmodule

// File: rtl/tpu_pass_sched.sv
// Job-level scheduler for the TPU core: splits a tiled-GEMV descriptor into
// M output tiles x K reduction passes, starts the core for each pass,
// requests one write-back per tile and reports job completion.
module tpu_pass_sched
  import tpu_pass_sched_pkg::*;
#(
  parameter int ARRAY_SIZE    = 8,
  parameter int K_ACCUM_DEPTH = 8,
  parameter int W_STRIDE      = ARRAY_SIZE,
  parameter int V_STRIDE      = K_ACCUM_DEPTH,
  parameter int TIMEOUT       = 511
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            job_valid_i,
  output logic            job_ready_o,
  input  logic [M_W-1:0]  job_m_tiles_i,
  input  logic [K_W-1:0]  job_k_tiles_i,
  input  logic [W_AW-1:0] job_w_base_i,
  input  logic [V_AW-1:0] job_v_base_i,
  input  logic [O_AW-1:0] job_o_base_i,
  output logic            core_start_o,
  output logic            core_acc_clear_o,
  output logic [W_AW-1:0] core_w_base_o,
  output logic [V_AW-1:0] core_v_base_o,
  input  logic            core_done_i,
  output logic            wb_en_o,
  output logic [O_AW-1:0] wb_addr_o,
  input  logic            wb_ready_i,
  output logic            busy_o,
  output logic            job_done_o,
  output logic [1:0]      err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  state_e          state_q,   state_d;
  logic [M_W-1:0]  m_idx_q,   m_idx_d;
  logic [K_W-1:0]  k_idx_q,   k_idx_d;
  logic [M_W-1:0]  m_tiles_q, m_tiles_d;
  logic [K_W-1:0]  k_tiles_q, k_tiles_d;
  logic [W_AW-1:0] w_base_q,  w_base_d;
  logic [V_AW-1:0] v_base_q,  v_base_d;
  logic [O_AW-1:0] o_base_q,  o_base_d;
  logic [TMO_W-1:0] tmo_q,    tmo_d;
  logic [1:0]      err_q,     err_d;

  logic            job_ready_q, busy_q, core_start_q, acc_clear_q;
  logic            wb_en_q, job_done_q;
  logic [O_AW-1:0] wb_addr_q;
  logic            load_s;

  // Next-state, counter and descriptor-latch logic
  always_comb begin
    state_d   = state_q;
    m_idx_d   = m_idx_q;
    k_idx_d   = k_idx_q;
    m_tiles_d = m_tiles_q;
    k_tiles_d = k_tiles_q;
    w_base_d  = w_base_q;
    v_base_d  = v_base_q;
    o_base_d  = o_base_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          m_tiles_d = job_m_tiles_i;
          k_tiles_d = job_k_tiles_i;
          w_base_d  = job_w_base_i;
          v_base_d  = job_v_base_i;
          o_base_d  = job_o_base_i;
          m_idx_d   = {M_W{1'b0}};
          k_idx_d   = {K_W{1'b0}};
          if ((job_m_tiles_i == {M_W{1'b0}}) || (job_k_tiles_i == {K_W{1'b0}})) begin
            err_d   = ERR_ZERO;
            state_d = ST_DONE;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // core_done takes priority over an expiring timeout
        if (core_done_i) begin
          if (k_idx_q == (k_tiles_q - 5'd1)) begin
            state_d = ST_WB;
          end else begin
            k_idx_d = k_idx_q + 5'd1;
            state_d = ST_ISSUE;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready_i) begin
          if (m_idx_q == (m_tiles_q - 6'd1)) begin
            state_d = ST_DONE;
          end else begin
            m_idx_d = m_idx_q + 6'd1;
            k_idx_d = {K_W{1'b0}};
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WB;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_s = (state_d == ST_ISSUE);

  // State, counters, latched descriptor and registered outputs
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= ST_IDLE;
      m_idx_q      <= {M_W{1'b0}};
      k_idx_q      <= {K_W{1'b0}};
      m_tiles_q    <= {M_W{1'b0}};
      k_tiles_q    <= {K_W{1'b0}};
      w_base_q     <= {W_AW{1'b0}};
      v_base_q     <= {V_AW{1'b0}};
      o_base_q     <= {O_AW{1'b0}};
      tmo_q        <= {TMO_W{1'b0}};
      err_q        <= ERR_OK;
      job_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      acc_clear_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= {O_AW{1'b0}};
      job_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_idx_q      <= m_idx_d;
      k_idx_q      <= k_idx_d;
      m_tiles_q    <= m_tiles_d;
      k_tiles_q    <= k_tiles_d;
      w_base_q     <= w_base_d;
      v_base_q     <= v_base_d;
      o_base_q     <= o_base_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      job_ready_q  <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      core_start_q <= load_s;
      acc_clear_q  <= load_s && (k_idx_d == {K_W{1'b0}});
      wb_en_q      <= (state_d == ST_WB);
      wb_addr_q    <= (state_d == ST_WB) ? (o_base_d + m_idx_d) : {O_AW{1'b0}};
      job_done_q   <= (state_d == ST_DONE);
    end
  end

  tpu_pass_sched_addr_gen #(
    .W_STRIDE (W_STRIDE),
    .V_STRIDE (V_STRIDE)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .load_i    (load_s),
    .m_idx_i   (m_idx_d),
    .k_idx_i   (k_idx_d),
    .k_tiles_i (k_tiles_d),
    .w_base_i  (w_base_d),
    .v_base_i  (v_base_d),
    .w_addr_o  (core_w_base_o),
    .v_addr_o  (core_v_base_o)
  );

  assign job_ready_o      = job_ready_q;
  assign busy_o           = busy_q;
  assign core_start_o     = core_start_q;
  assign core_acc_clear_o = acc_clear_q;
  assign wb_en_o          = wb_en_q;
  assign wb_addr_o        = wb_addr_q;
  assign job_done_o       = job_done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_tpu_pass_sched.sv
// Directed bench for tpu_pass_sched: a small core/write-back responder logs
// every core start and write-back, and each job is checked against
// hand-computed bases, counts and latencies.
module tb_tpu_pass_sched;

  logic       clk_i = 1'b0;
  logic       srst_i, job_valid_i, job_ready_o;
  logic [5:0] job_m_tiles_i;
  logic [4:0] job_k_tiles_i;
  logic [5:0] job_w_base_i;
  logic [4:0] job_v_base_i;
  logic [5:0] job_o_base_i;
  logic       core_start_o, core_acc_clear_o, core_done_i;
  logic [5:0] core_w_base_o;
  logic [4:0] core_v_base_o;
  logic       wb_en_o, wb_ready_i, busy_o, job_done_o;
  logic [5:0] wb_addr_o;
  logic [1:0] err_o;

  always #5 clk_i = ~clk_i;

  tpu_pass_sched dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_m_tiles_i(job_m_tiles_i), .job_k_tiles_i(job_k_tiles_i),
    .job_w_base_i(job_w_base_i), .job_v_base_i(job_v_base_i), .job_o_base_i(job_o_base_i),
    .core_start_o(core_start_o), .core_acc_clear_o(core_acc_clear_o),
    .core_w_base_o(core_w_base_o), .core_v_base_o(core_v_base_o),
    .core_done_i(core_done_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_ready_i(wb_ready_i),
    .busy_o(busy_o), .job_done_o(job_done_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycle counter and responder/monitor state
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_start = 0, n_wb = 0, n_done = 0, done_cyc = 0, cd_cnt = 0;
  int stall_seen = 0, stall_addr_bad = 0;
  int w_log[256], v_log[256], c_log[256], s_cyc[256], wb_log[256], wb_cyc[256];
  int  core_lat = 10;
  bit  core_auto = 1'b1;
  bit  force_done = 1'b0;
  int  wb_stall_req = 0;
  int  stall_addr = 0;

  // core and write-back responder, sampling on the falling edge
  initial begin
    core_done_i = 1'b0;
    wb_ready_i  = 1'b0;
    forever begin
      @(negedge clk_i);
      core_done_i = force_done;
      wb_ready_i  = 1'b0;
      if (core_start_o) begin
        w_log[n_start] = int'(core_w_base_o);
        v_log[n_start] = int'(core_v_base_o);
        c_log[n_start] = int'(core_acc_clear_o);
        s_cyc[n_start] = cyc;
        n_start++;
        cd_cnt = core_auto ? core_lat : 0;
      end else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) core_done_i = 1'b1;
      end
      if (wb_en_o) begin
        if (stall_seen < wb_stall_req) begin
          stall_seen++;
          if (int'(wb_addr_o) != stall_addr) stall_addr_bad++;
        end else begin
          wb_ready_i = 1'b1;
          wb_log[n_wb] = int'(wb_addr_o);
          wb_cyc[n_wb] = cyc;
          n_wb++;
        end
      end
      if (job_done_o) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Issue one descriptor and wait (bounded) for its job_done pulse
  task automatic run_job(input int m, input int k, input int w, input int v, input int o,
                         input int budget, output int acc_cyc);
    int d0;
    d0 = n_done;
    @(negedge clk_i);
    chk("ready_before_job", job_ready_o, 1);
    job_m_tiles_i = 6'(m);
    job_k_tiles_i = 5'(k);
    job_w_base_i  = 6'(w);
    job_v_base_i  = 5'(v);
    job_o_base_i  = 6'(o);
    job_valid_i   = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    acc_cyc = cyc;
    #1;
    for (int i = 0; i < budget && n_done == d0; i++) begin
      @(negedge clk_i);
      #1;
    end
    if (n_done == d0) chk("job_done_timeout", 0, 1);
  endtask

  int acc, s0, w0, d0, st0;
  int exp_w2[6] = '{4, 12, 20, 28, 36, 44};
  int exp_v2[6] = '{2, 10, 18, 2, 10, 18};
  int exp_c2[6] = '{1, 0, 0, 1, 0, 0};
  int exp_w7[9] = '{60, 4, 12, 20, 28, 36, 44, 52, 60};
  int exp_v7[3] = '{30, 6, 14};

  initial begin
    srst_i = 1'b1; job_valid_i = 1'b0;
    job_m_tiles_i = 6'd0; job_k_tiles_i = 5'd0;
    job_w_base_i = 6'd0; job_v_base_i = 5'd0; job_o_base_i = 6'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_job_ready", job_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_core_start", core_start_o, 0);
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_job_done", job_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_w_base", core_w_base_o, 0);
    srst_i = 1'b0;

    // 1: single pass, zero bases
    s0 = n_start; w0 = n_wb; d0 = n_done;
    run_job(1, 1, 0, 0, 0, 200, acc);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_acc_clear", c_log[s0], 1);
    chk("t1_w_base", w_log[s0], 0);
    chk("t1_start_latency", s_cyc[s0] - acc, 0);
    chk("t1_wbs", n_wb - w0, 1);
    chk("t1_wb_addr", wb_log[w0], 0);
    chk("t1_done_pulses", n_done - d0, 1);
    chk("t1_err", err_o, 0);

    // 2: m=2,k=3 with base offsets, output base wraps
    s0 = n_start; w0 = n_wb;
    run_job(2, 3, 4, 2, 63, 400, acc);
    chk("t2_starts", n_start - s0, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_w_base%0d", i), w_log[s0 + i], exp_w2[i]);
      chk($sformatf("t2_v_base%0d", i), v_log[s0 + i], exp_v2[i]);
      chk($sformatf("t2_clr%0d", i), c_log[s0 + i], exp_c2[i]);
    end
    chk("t2_wbs", n_wb - w0, 2);
    chk("t2_wb_addr0", wb_log[w0], 63);
    chk("t2_wb_addr1", wb_log[w0 + 1], 0);
    chk("t2_issue_after_wb", s_cyc[s0 + 3] - wb_cyc[w0], 1);
    chk("t2_err", err_o, 0);

    // 3: zero tile counts
    s0 = n_start; d0 = n_done;
    run_job(0, 3, 0, 0, 0, 20, acc);
    chk("t3_no_start", n_start - s0, 0);
    chk("t3_done_latency", done_cyc - acc, 0);
    chk("t3_done_pulses", n_done - d0, 1);
    chk("t3_err", err_o, 1);
    s0 = n_start;
    run_job(2, 0, 0, 0, 0, 20, acc);
    chk("t3k_no_start", n_start - s0, 0);
    chk("t3k_err", err_o, 1);

    // 4: core never answers -> timeout, then a clean job clears err
    core_auto = 1'b0;
    s0 = n_start; w0 = n_wb;
    run_job(1, 1, 0, 0, 0, 700, acc);
    chk("t4_done_latency", done_cyc - acc, 513);
    chk("t4_err", err_o, 2);
    chk("t4_no_wb", n_wb - w0, 0);
    core_auto = 1'b1;
    run_job(1, 1, 0, 0, 0, 200, acc);
    chk("t4_err_cleared", err_o, 0);

    // 5: first write-back stalled 5 cycles
    s0 = n_start; w0 = n_wb; st0 = stall_seen;
    stall_addr = 10;
    wb_stall_req = stall_seen + 5;
    run_job(2, 1, 0, 0, 10, 300, acc);
    chk("t5_stall_cycles", stall_seen - st0, 5);
    chk("t5_stall_addr_bad", stall_addr_bad, 0);
    chk("t5_wb_addr0", wb_log[w0], 10);
    chk("t5_wb_addr1", wb_log[w0 + 1], 11);
    chk("t5_issue_after_wb", s_cyc[s0 + 1] - wb_cyc[w0], 1);

    // 6: srst in WAIT, then core_done while idle
    core_auto = 1'b0;
    d0 = n_done;
    @(negedge clk_i);
    job_m_tiles_i = 6'd1; job_k_tiles_i = 5'd1; job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t6_busy_in_wait", busy_o, 1);
    srst_i = 1'b1;
    @(negedge clk_i);
    chk("t6_ready_after_srst", job_ready_o, 1);
    chk("t6_idle_after_srst", busy_o, 0);
    srst_i = 1'b0;
    core_auto = 1'b1;
    s0 = n_start;
    @(negedge clk_i);
    #2 force_done = 1'b1;
    @(negedge clk_i);
    #2 force_done = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_done_ignored_start", n_start - s0, 0);
    chk("t6_done_ignored_busy", busy_o, 0);

    // 7: weight and vector bases wrap, pass index crosses tiles
    s0 = n_start;
    run_job(3, 3, 60, 30, 0, 600, acc);
    chk("t7_starts", n_start - s0, 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t7_w_base%0d", i), w_log[s0 + i], exp_w7[i]);
      chk($sformatf("t7_v_base%0d", i), v_log[s0 + i], exp_v7[i % 3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
